// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Provides the FSM state encoding, the default operand width and the
// helper that sizes the bit counter for a given operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        if (cw < 1) begin
            cw = 1;
        end
        return cw;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, purely combinational.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
// Used once by serial_add_ctrl, which owns every register around it.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH-bit operands LSB first,
// one bit per clock, with the carry held in a flip-flop between bits.
// Ports: clk, rst (sync, active high), start/a/b/cin in; busy, done, sum, cout
// out; ovf out only when SERIAL_ADD_OVF_EN is defined (signed overflow flag).
// Latency: start accepted at edge k -> done high in the cycle after edge
// k+WIDTH. start is ignored while busy; it is accepted in IDLE and in FIN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 sum bits produced before the final bit edge; the
    // final bit is merged in directly when the result is published.
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic fa_s;
    logic fa_co;
    logic load;
    logic shift;
    logic last;

    fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign sum_next = {fa_s, sum_sr};

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                // Accepting start here gives back-to-back operation.
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (load) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (shift) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_next[WIDTH-1:1];
            carry_q <= fa_co;
            if (last) begin
                // Publish result; outputs stay frozen until the next one.
                sum  <= sum_next;
                cout <= fa_co;
                busy <= 1'b0;
                done <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                // carry_q is the carry into the MSB on this final edge.
                ovf  <= carry_q ^ fa_co;
`endif
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule
